// File: rtl/tl_d_width_splitter_if.sv
// ---------------------------------------------------------------------------
// tl_d_width_splitter_if
//
// Bundles the TileLink D-channel signals around the width splitter: the wide
// enq side (from the wide D source) and the narrow deq side (to the client).
//
// Modports:
//   master - the environment: drives the wide beat, its byte offset and the
//            narrow-side ready; observes enq ready and the narrow beat.
//   slave  - the splitter: consumes the wide beat and produces narrow beats.
//
// Signals (widths follow the parameters):
//   io_enq_valid / io_enq_ready         wide beat handshake
//   io_enq_bits_*                       wide D fields (data is 8*IN_BYTES)
//   io_enq_offset                       byte offset of transfer in wide beat
//   io_deq_valid / io_deq_ready         narrow beat handshake
//   io_deq_bits_*                       narrow D fields (data is 8*OUT_BYTES)
//   io_deq_last                         final narrow beat of the wide beat
// ---------------------------------------------------------------------------
interface tl_d_width_splitter_if #(
    parameter int IN_BYTES  = 16,
    parameter int OUT_BYTES = 4,
    parameter int SOURCE_W  = 4,
    parameter int SINK_W    = 4
);
    localparam int OFF_W = $clog2(IN_BYTES);

    logic                   io_enq_valid;
    logic                   io_enq_ready;
    logic [2:0]             io_enq_bits_opcode;
    logic [1:0]             io_enq_bits_param;
    logic [3:0]             io_enq_bits_size;
    logic [SOURCE_W-1:0]    io_enq_bits_source;
    logic [SINK_W-1:0]      io_enq_bits_sink;
    logic                   io_enq_bits_denied;
    logic [8*IN_BYTES-1:0]  io_enq_bits_data;
    logic                   io_enq_bits_corrupt;
    logic [OFF_W-1:0]       io_enq_offset;

    logic                   io_deq_ready;
    logic                   io_deq_valid;
    logic [2:0]             io_deq_bits_opcode;
    logic [1:0]             io_deq_bits_param;
    logic [3:0]             io_deq_bits_size;
    logic [SOURCE_W-1:0]    io_deq_bits_source;
    logic [SINK_W-1:0]      io_deq_bits_sink;
    logic                   io_deq_bits_denied;
    logic [8*OUT_BYTES-1:0] io_deq_bits_data;
    logic                   io_deq_bits_corrupt;
    logic                   io_deq_last;

    modport master (
        output io_enq_valid, io_enq_bits_opcode, io_enq_bits_param,
               io_enq_bits_size, io_enq_bits_source, io_enq_bits_sink,
               io_enq_bits_denied, io_enq_bits_data, io_enq_bits_corrupt,
               io_enq_offset, io_deq_ready,
        input  io_enq_ready, io_deq_valid, io_deq_bits_opcode,
               io_deq_bits_param, io_deq_bits_size, io_deq_bits_source,
               io_deq_bits_sink, io_deq_bits_denied, io_deq_bits_data,
               io_deq_bits_corrupt, io_deq_last
    );

    modport slave (
        input  io_enq_valid, io_enq_bits_opcode, io_enq_bits_param,
               io_enq_bits_size, io_enq_bits_source, io_enq_bits_sink,
               io_enq_bits_denied, io_enq_bits_data, io_enq_bits_corrupt,
               io_enq_offset, io_deq_ready,
        output io_enq_ready, io_deq_valid, io_deq_bits_opcode,
               io_deq_bits_param, io_deq_bits_size, io_deq_bits_source,
               io_deq_bits_sink, io_deq_bits_denied, io_deq_bits_data,
               io_deq_bits_corrupt, io_deq_last
    );
endinterface

// File: rtl/tl_d_width_splitter.sv
// ---------------------------------------------------------------------------
// tl_d_width_splitter
//
// Narrows a TileLink D-channel beat stream from an IN_BYTES data bus to an
// OUT_BYTES data bus. Each accepted wide beat becomes 1, 2 or 4 (up to
// IN_BYTES/OUT_BYTES) narrow beats depending on opcode and size. The first
// narrow beat passes straight through from the enq inputs; the remaining
// beats are replayed from a holding register.
//
// Ports:
//   clock  - sole clock
//   reset  - asynchronous, active-low reset
//   bus    - tl_d_width_splitter_if.slave: wide enq side, offset, narrow deq
//            side. The interface instance must use the same parameters.
// ---------------------------------------------------------------------------
module tl_d_width_splitter #(
    parameter int IN_BYTES  = 16,
    parameter int OUT_BYTES = 4,
    parameter int SOURCE_W  = 4,
    parameter int SINK_W    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    tl_d_width_splitter_if.slave  bus
);
    localparam int RATIO    = IN_BYTES / OUT_BYTES;
    localparam int IDX_W    = $clog2(RATIO);
    localparam int CNT_W    = IDX_W + 1;
    localparam int OFF_W    = $clog2(IN_BYTES);
    localparam int IN_SH    = $clog2(IN_BYTES);
    localparam int OUT_SH   = $clog2(OUT_BYTES);
    localparam int IN_BITS  = 8 * IN_BYTES;
    localparam int OUT_BITS = 8 * OUT_BYTES;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 stateQ, stateD;
    logic [IDX_W-1:0]       idxQ, idxD;
    logic                   captureEn;

    // Saved copy of the wide beat being replayed
    logic [2:0]             opcodeQ;
    logic [1:0]             paramQ;
    logic [3:0]             sizeQ;
    logic [SOURCE_W-1:0]    sourceQ;
    logic [SINK_W-1:0]      sinkQ;
    logic                   deniedQ;
    logic                   corruptQ;
    logic [IN_BITS-1:0]     dataQ;
    logic [OFF_W-1:0]       offsetQ;
    logic [CNT_W-1:0]       nQ;

    logic [CNT_W-1:0]       liveN;
    logic [IDX_W-1:0]       liveBase;
    logic [IDX_W-1:0]       savedBase;
    logic [IDX_W-1:0]       laneSel;
    logic [IN_BITS-1:0]     dataSrc;

    // Only AccessAckData and GrantData carry payload
    function automatic logic isDataOp(input logic [2:0] op);
        return (op == 3'd1) || (op == 3'd5);
    endfunction

    // Narrow beats per wide beat: max(1, min(2^size, IN_BYTES)/OUT_BYTES)
    function automatic logic [CNT_W-1:0] beatCount(input logic [2:0] op,
                                                    input logic [3:0] size);
        if (!isDataOp(op))            return CNT_W'(1);
        if (size >= 4'(IN_SH))        return CNT_W'(RATIO);
        if (size <= 4'(OUT_SH))       return CNT_W'(1);
        return CNT_W'(1) << (size - 4'(OUT_SH));
    endfunction

    // First lane of the transfer, aligned down to the burst length so a
    // multi-beat transfer always starts on its natural boundary
    function automatic logic [IDX_W-1:0] baseLane(input logic [OFF_W-1:0] off,
                                                   input logic [3:0]       size,
                                                   input logic [CNT_W-1:0] n);
        logic [IDX_W-1:0] mask;
        mask = IDX_W'(n - CNT_W'(1));
        if (size >= 4'(IN_SH)) return '0;
        return off[OFF_W-1:OUT_SH] & ~mask;
    endfunction

    // Control state: cleared asynchronously so an interrupted burst is dropped
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ <= IDLE;
            idxQ   <= '0;
        end else begin
            stateQ <= stateD;
            idxQ   <= idxD;
        end
    end

    // Holding register: loads only when a multi-beat wide beat is accepted
    always_ff @(posedge clock) begin
        if (captureEn) begin
            opcodeQ  <= bus.io_enq_bits_opcode;
            paramQ   <= bus.io_enq_bits_param;
            sizeQ    <= bus.io_enq_bits_size;
            sourceQ  <= bus.io_enq_bits_source;
            sinkQ    <= bus.io_enq_bits_sink;
            deniedQ  <= bus.io_enq_bits_denied;
            corruptQ <= bus.io_enq_bits_corrupt;
            dataQ    <= bus.io_enq_bits_data;
            offsetQ  <= bus.io_enq_offset;
            nQ       <= liveN;
        end
    end

    // Next state and outputs. Idle is a combinational pass-through of the
    // live enq beat; busy replays the saved beat lane by lane.
    always_comb begin
        stateD    = stateQ;
        idxD      = idxQ;
        captureEn = 1'b0;

        liveN     = beatCount(bus.io_enq_bits_opcode, bus.io_enq_bits_size);
        liveBase  = baseLane(bus.io_enq_offset, bus.io_enq_bits_size, liveN);
        savedBase = baseLane(offsetQ, sizeQ, nQ);

        bus.io_enq_ready        = bus.io_deq_ready;
        bus.io_deq_valid        = bus.io_enq_valid;
        bus.io_deq_bits_opcode  = bus.io_enq_bits_opcode;
        bus.io_deq_bits_param   = bus.io_enq_bits_param;
        bus.io_deq_bits_size    = bus.io_enq_bits_size;
        bus.io_deq_bits_source  = bus.io_enq_bits_source;
        bus.io_deq_bits_sink    = bus.io_enq_bits_sink;
        bus.io_deq_bits_denied  = bus.io_enq_bits_denied;
        bus.io_deq_bits_corrupt = bus.io_enq_bits_corrupt;
        bus.io_deq_last         = (liveN == CNT_W'(1));
        laneSel                 = liveBase;
        dataSrc                 = bus.io_enq_bits_data;

        if (stateQ == IDLE) begin
            // The wide beat is consumed together with its first narrow beat
            if (bus.io_enq_valid && bus.io_deq_ready && (liveN != CNT_W'(1))) begin
                captureEn = 1'b1;
                stateD    = BUSY;
                idxD      = IDX_W'(1);
            end
        end else begin
            bus.io_enq_ready        = 1'b0;
            bus.io_deq_valid        = 1'b1;
            bus.io_deq_bits_opcode  = opcodeQ;
            bus.io_deq_bits_param   = paramQ;
            bus.io_deq_bits_size    = sizeQ;
            bus.io_deq_bits_source  = sourceQ;
            bus.io_deq_bits_sink    = sinkQ;
            bus.io_deq_bits_denied  = deniedQ;
            bus.io_deq_bits_corrupt = corruptQ;
            bus.io_deq_last         = ({1'b0, idxQ} == (nQ - CNT_W'(1)));
            laneSel                 = savedBase + idxQ;
            dataSrc                 = dataQ;

            if (bus.io_deq_ready) begin
                if (bus.io_deq_last) begin
                    stateD = IDLE;
                    idxD   = '0;
                end else begin
                    idxD   = idxQ + IDX_W'(1);
                end
            end
        end

        bus.io_deq_bits_data = dataSrc[laneSel*OUT_BITS +: OUT_BITS];
    end
endmodule

// File: tb/tb_tl_d_width_splitter.sv
// ---------------------------------------------------------------------------
// tb_tl_d_width_splitter
//
// Directed bench for the 128-to-32 bit D-channel splitter. A table of wide
// beats with hand-computed narrow beats is streamed back to back, followed by
// hand-written stall and mid-burst reset sequences.
// ---------------------------------------------------------------------------
module tb_tl_d_width_splitter;

    typedef struct {
        logic [2:0]       opcode;
        logic [1:0]       param;
        logic [3:0]       size;
        logic [3:0]       source;
        logic [3:0]       sink;
        logic             denied;
        logic             corrupt;
        logic [3:0]       offset;
        logic [127:0]     data;
        int               nBeats;
        logic [3:0][31:0] expData;
    } vec_t;

    localparam logic [127:0] DATA_A = 128'h33333333_22222222_11111111_00000000;
    localparam logic [127:0] DATA_B = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [127:0] JUNK   = 128'h5A5A5A5A_A5A5A5A5_F0F0F0F0_0F0F0F0F;

    logic clock;
    logic rstN;
    int   vectorCount;
    int   missCount;
    int   fires;
    vec_t vecs[$];

    int          readyPat[6] = '{1, 0, 0, 1, 1, 1};
    logic [31:0] stallLane[6] = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hBBBBBBBB,
                                  32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};

    tl_d_width_splitter_if #(.IN_BYTES(16), .OUT_BYTES(4), .SOURCE_W(4), .SINK_W(4)) bus ();

    tl_d_width_splitter #(.IN_BYTES(16), .OUT_BYTES(4), .SOURCE_W(4), .SINK_W(4)) dut (
        .clock (clock),
        .reset (rstN),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic [2:0] opcode, input logic [3:0] size,
                          input logic [3:0] offset, input logic [127:0] data,
                          input int nBeats, input logic [3:0][31:0] expData);
        vec_t v;
        int   k;
        k         = vecs.size();
        v.opcode  = opcode;
        v.param   = 2'(k);
        v.size    = size;
        v.source  = 4'(k);
        v.sink    = 4'(15 - k);
        v.denied  = k[0];
        v.corrupt = k[1];
        v.offset  = offset;
        v.data    = data;
        v.nBeats  = nBeats;
        v.expData = expData;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.io_enq_valid        = 1'b1;
        bus.io_enq_bits_opcode  = v.opcode;
        bus.io_enq_bits_param   = v.param;
        bus.io_enq_bits_size    = v.size;
        bus.io_enq_bits_source  = v.source;
        bus.io_enq_bits_sink    = v.sink;
        bus.io_enq_bits_denied  = v.denied;
        bus.io_enq_bits_corrupt = v.corrupt;
        bus.io_enq_offset       = v.offset;
        bus.io_enq_bits_data    = v.data;
    endtask

    // Scrambles the enq side so busy beats can only come from saved state
    task automatic scrambleEnq();
        bus.io_enq_valid        = 1'b0;
        bus.io_enq_bits_opcode  = 3'd7;
        bus.io_enq_bits_param   = 2'd3;
        bus.io_enq_bits_size    = 4'd0;
        bus.io_enq_bits_source  = 4'hF;
        bus.io_enq_bits_sink    = 4'h0;
        bus.io_enq_bits_denied  = 1'b0;
        bus.io_enq_bits_corrupt = 1'b0;
        bus.io_enq_offset       = 4'd0;
        bus.io_enq_bits_data    = JUNK;
    endtask

    function automatic vec_t mkSimple(input logic [2:0] opcode, input logic [3:0] size,
                                      input logic [3:0] offset, input logic [127:0] data);
        vec_t v;
        v.opcode = opcode; v.param = 2'd0; v.size = size; v.source = 4'd9;
        v.sink = 4'd6; v.denied = 1'b0; v.corrupt = 1'b1; v.offset = offset;
        v.data = data; v.nBeats = 1; v.expData = '0;
        return v;
    endfunction

    initial begin
        vectorCount = 0;
        missCount   = 0;
        fires       = 0;

        addVec(3'd0, 4'd6, 4'd0,  DATA_A, 1, {32'h0, 32'h0, 32'h0, 32'h00000000});
        addVec(3'd1, 4'd4, 4'd0,  DATA_A, 4, {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000});
        addVec(3'd1, 4'd3, 4'd8,  DATA_A, 2, {32'h0, 32'h0, 32'h33333333, 32'h22222222});
        addVec(3'd5, 4'd2, 4'd12, DATA_A, 1, {32'h0, 32'h0, 32'h0, 32'h33333333});
        addVec(3'd1, 4'd3, 4'd4,  DATA_A, 2, {32'h0, 32'h0, 32'h11111111, 32'h00000000});
        addVec(3'd1, 4'd5, 4'd4,  DATA_B, 4, {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA});
        addVec(3'd0, 4'd2, 4'd12, DATA_A, 1, {32'h0, 32'h0, 32'h0, 32'h33333333});
        addVec(3'd5, 4'd0, 4'd6,  DATA_A, 1, {32'h0, 32'h0, 32'h0, 32'h11111111});
        addVec(3'd4, 4'd4, 4'd8,  DATA_B, 1, {32'h0, 32'h0, 32'h0, 32'hAAAAAAAA});
        addVec(3'd5, 4'd6, 4'd12, DATA_B, 4, {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA});

        // Reset state
        rstN = 1'b0;
        scrambleEnq();
        bus.io_deq_ready = 1'b1;
        #3;
        checkOutput("reset deq_valid", 128'(bus.io_deq_valid), 128'(1'b0));
        checkOutput("reset enq_ready follows 1", 128'(bus.io_enq_ready), 128'(1'b1));
        bus.io_deq_ready = 1'b0;
        #1;
        checkOutput("reset enq_ready follows 0", 128'(bus.io_enq_ready), 128'(1'b0));
        @(negedge clock);
        rstN = 1'b1;
        #1;
        checkOutput("idle enq_ready follows 0", 128'(bus.io_enq_ready), 128'(1'b0));
        bus.io_deq_ready = 1'b1;
        #1;
        checkOutput("idle enq_ready follows 1", 128'(bus.io_enq_ready), 128'(1'b1));
        @(negedge clock);

        // Table vectors, streamed back to back with deq_ready held high
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            bus.io_deq_ready = 1'b1;
            for (int b = 0; b < vecs[i].nBeats; b++) begin
                if (b == 1) scrambleEnq();
                #1;
                checkOutput($sformatf("v%0d b%0d valid", i, b), 128'(bus.io_deq_valid), 128'(1'b1));
                checkOutput($sformatf("v%0d b%0d data", i, b), 128'(bus.io_deq_bits_data),
                            128'(vecs[i].expData[b]));
                checkOutput($sformatf("v%0d b%0d last", i, b), 128'(bus.io_deq_last),
                            128'(b == vecs[i].nBeats - 1));
                checkOutput($sformatf("v%0d b%0d enq_ready", i, b), 128'(bus.io_enq_ready),
                            128'(b == 0));
                checkOutput($sformatf("v%0d b%0d fields", i, b),
                            128'({bus.io_deq_bits_opcode, bus.io_deq_bits_param, bus.io_deq_bits_size,
                                  bus.io_deq_bits_source, bus.io_deq_bits_sink,
                                  bus.io_deq_bits_denied, bus.io_deq_bits_corrupt}),
                            128'({vecs[i].opcode, vecs[i].param, vecs[i].size, vecs[i].source,
                                  vecs[i].sink, vecs[i].denied, vecs[i].corrupt}));
                @(negedge clock);
            end
        end
        scrambleEnq();
        #1;
        checkOutput("post table idle valid", 128'(bus.io_deq_valid), 128'(1'b0));
        @(negedge clock);

        // Stall sequence: deq_ready 1,0,0,1,1,1 over a 4-beat burst
        applyStimulus(mkSimple(3'd1, 4'd4, 4'd0, DATA_B));
        for (int c = 0; c < 6; c++) begin
            bus.io_deq_ready = readyPat[c][0];
            if (c == 1) scrambleEnq();
            if (c == 5) applyStimulus(mkSimple(3'd0, 4'd2, 4'd4, DATA_A));
            #1;
            checkOutput($sformatf("stall c%0d valid", c), 128'(bus.io_deq_valid), 128'(1'b1));
            checkOutput($sformatf("stall c%0d data", c), 128'(bus.io_deq_bits_data), 128'(stallLane[c]));
            checkOutput($sformatf("stall c%0d last", c), 128'(bus.io_deq_last), 128'(c == 5));
            checkOutput($sformatf("stall c%0d enq_ready", c), 128'(bus.io_enq_ready), 128'(c == 0));
            if (bus.io_deq_valid && bus.io_deq_ready) fires++;
            @(negedge clock);
        end
        checkOutput("stall fire count", 128'(fires), 128'(4));
        bus.io_deq_ready = 1'b1;
        #1;
        checkOutput("next beat enq_ready", 128'(bus.io_enq_ready), 128'(1'b1));
        checkOutput("next beat data", 128'(bus.io_deq_bits_data), 128'(32'h11111111));
        checkOutput("next beat last", 128'(bus.io_deq_last), 128'(1'b1));
        @(negedge clock);
        scrambleEnq();

        // Mid-burst reset after the second narrow beat
        applyStimulus(mkSimple(3'd1, 4'd4, 4'd0, DATA_A));
        #1;
        checkOutput("rst burst b0 data", 128'(bus.io_deq_bits_data), 128'(32'h00000000));
        @(negedge clock);
        scrambleEnq();
        #1;
        checkOutput("rst burst b1 data", 128'(bus.io_deq_bits_data), 128'(32'h11111111));
        @(negedge clock);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("mid reset deq_valid", 128'(bus.io_deq_valid), 128'(1'b0));
        checkOutput("mid reset enq_ready", 128'(bus.io_enq_ready), 128'(1'b1));
        bus.io_deq_ready = 1'b0;
        #1;
        checkOutput("mid reset enq_ready low", 128'(bus.io_enq_ready), 128'(1'b0));
        @(negedge clock);
        rstN = 1'b1;
        bus.io_deq_ready = 1'b1;
        applyStimulus(mkSimple(3'd5, 4'd2, 4'd4, DATA_B));
        #1;
        checkOutput("after reset valid", 128'(bus.io_deq_valid), 128'(1'b1));
        checkOutput("after reset data", 128'(bus.io_deq_bits_data), 128'(32'hBBBBBBBB));
        checkOutput("after reset last", 128'(bus.io_deq_last), 128'(1'b1));
        checkOutput("after reset enq_ready", 128'(bus.io_enq_ready), 128'(1'b1));
        @(negedge clock);
        scrambleEnq();
        #1;
        checkOutput("no stale beat", 128'(bus.io_deq_valid), 128'(1'b0));
        @(negedge clock);
        #1;
        checkOutput("no stale beat 2", 128'(bus.io_deq_valid), 128'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
